// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control types and constants.
// Holds the quadrature step codes and the Gray-code step classifier.
package motor_ctrl_pkg;

  localparam int RPM_W   = 16;
  localparam int RPM_MAX = 32767;
  localparam int ACC_W   = 24;
  localparam int PROD_W  = 40;

  localparam logic [1:0] STEP_NONE    = 2'd0;
  localparam logic [1:0] STEP_FWD     = 2'd1;
  localparam logic [1:0] STEP_REV     = 2'd2;
  localparam logic [1:0] STEP_ILLEGAL = 2'd3;

  // Position of an {A,B} pair along the cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    diff = gray_pos(cur) - gray_pos(prev);
    case (diff)
      2'd0:    return STEP_NONE;
      2'd1:    return STEP_FWD;
      2'd3:    return STEP_REV;
      default: return STEP_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: 2-FF synchroniser followed by a stability filter.
// locked rises once the first stable level has been accepted after reset.
module quad_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic locked
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(FILTER_LEN);

  logic [1:0]    sync;
  logic [1:0]    fill;
  logic          last;
  logic [CW-1:0] run;
  logic [CW-1:0] run_next;

  // Length of the current streak of identical synced samples, saturating.
  always_comb begin
    run_next = run;
    if (run == '0 || sync[1] != last) begin
      run_next = CW'(1);
    end else if (run != RUN_MAX) begin
      run_next = run + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      fill   <= '0;
      last   <= 1'b0;
      run    <= '0;
      level  <= 1'b0;
      locked <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fill <= {fill[0], 1'b1};
      // Ignore the synchroniser until it holds real samples, not reset zeros.
      if (fill[1]) begin
        last <= sync[1];
        run  <= run_next;
        if (run_next == RUN_MAX) begin
          level  <= sync[1];
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/encoder_rpm_meter.sv
// Quadrature encoder front end: x4 decode, gated signed edge count,
// scaled to saturated signed RPM once per window.
module encoder_rpm_meter
  import motor_ctrl_pkg::*;
#(
  parameter int WINDOW_CYCLES = 5_000_000,
  parameter int FILTER_LEN    = 3,
  parameter int RPM_MULT      = 1,
  parameter int RPM_SHIFT     = 1,
  parameter int DIR_INVERT    = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enc_A,
  input  logic             Enc_B,
  output logic [RPM_W-1:0] RPM_Measured,
  output logic             RPM_Valid,
  output logic             Quad_Error
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  localparam logic signed [1:0] FWD_DELTA = (DIR_INVERT != 0) ? -2'sd1 : 2'sd1;
  localparam logic signed [1:0] REV_DELTA = -FWD_DELTA;

  localparam logic signed [ACC_W:0] ACC_POS = (ACC_W + 1)'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] ACC_NEG = -ACC_POS;

  localparam logic signed [PROD_W-1:0] MULT_S     = PROD_W'(RPM_MULT);
  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'((2 ** RPM_SHIFT) - 1);
  localparam logic signed [PROD_W-1:0] RPM_POS    = PROD_W'(RPM_MAX);
  localparam logic signed [PROD_W-1:0] RPM_NEG    = -RPM_POS;

  logic level_a;
  logic level_b;
  logic locked_a;
  logic locked_b;

  logic [1:0]        cur_ab;
  logic [1:0]        prev_ab;
  logic              primed;
  logic              both_locked;
  logic [1:0]        step;
  logic signed [1:0] delta;
  logic              illegal;

  logic [WIN_W-1:0]        win_cnt;
  logic                    terminal;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_next;

  logic signed [ACC_W-1:0]  latched;
  logic                     lat_valid;
  logic signed [PROD_W-1:0] lat_ext;
  logic signed [PROD_W-1:0] product;
  logic                     prod_valid;
  logic signed [PROD_W-1:0] biased;
  logic signed [PROD_W-1:0] shifted;
  logic [RPM_W-1:0]         rpm_sat;

  quad_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) filter_a (
    .clk   (Clk),
    .reset (Reset),
    .raw   (Enc_A),
    .level (level_a),
    .locked(locked_a)
  );

  quad_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) filter_b (
    .clk   (Clk),
    .reset (Reset),
    .raw   (Enc_B),
    .level (level_b),
    .locked(locked_b)
  );

  assign cur_ab      = {level_a, level_b};
  assign both_locked = locked_a & locked_b;
  assign terminal    = (win_cnt == WIN_LAST);

  // Nothing is decoded until the history holds a real filtered sample.
  always_comb begin
    step    = quad_step(prev_ab, cur_ab);
    delta   = 2'sd0;
    illegal = 1'b0;
    if (primed && both_locked) begin
      case (step)
        STEP_FWD:     delta = FWD_DELTA;
        STEP_REV:     delta = REV_DELTA;
        STEP_ILLEGAL: illegal = 1'b1;
        default:      delta = 2'sd0;
      endcase
    end
  end

  always_comb begin
    acc_sum  = {acc[ACC_W-1], acc} + {{(ACC_W - 1){delta[1]}}, delta};
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum > ACC_POS) begin
      acc_next = ACC_POS[ACC_W-1:0];
    end else if (acc_sum < ACC_NEG) begin
      acc_next = ACC_NEG[ACC_W-1:0];
    end
  end

  assign lat_ext = {{(PROD_W - ACC_W){latched[ACC_W-1]}}, latched};

  // Negative products are biased first so the arithmetic shift truncates toward zero.
  always_comb begin
    biased = product;
    if (product[PROD_W-1]) begin
      biased = product + ROUND_BIAS;
    end
    shifted = biased >>> RPM_SHIFT;
    rpm_sat = shifted[RPM_W-1:0];
    if (shifted > RPM_POS) begin
      rpm_sat = RPM_POS[RPM_W-1:0];
    end else if (shifted < RPM_NEG) begin
      rpm_sat = RPM_NEG[RPM_W-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_ab      <= 2'b00;
      primed       <= 1'b0;
      Quad_Error   <= 1'b0;
      win_cnt      <= '0;
      acc          <= '0;
      latched      <= '0;
      lat_valid    <= 1'b0;
      product      <= '0;
      prod_valid   <= 1'b0;
      RPM_Measured <= '0;
      RPM_Valid    <= 1'b0;
    end else begin
      if (both_locked) begin
        prev_ab <= cur_ab;
        primed  <= 1'b1;
      end
      if (illegal) begin
        Quad_Error <= 1'b1;
      end

      win_cnt <= terminal ? '0 : win_cnt + WIN_W'(1);
      if (terminal) begin
        latched <= acc_next;
        acc     <= '0;
      end else begin
        acc <= acc_next;
      end
      lat_valid <= terminal;

      if (lat_valid) begin
        product <= lat_ext * MULT_S;
      end
      prod_valid <= lat_valid;

      if (prod_valid) begin
        RPM_Measured <= rpm_sat;
      end
      RPM_Valid <= prod_valid;
    end
  end

endmodule
